// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared state encoding and default widths for the LC-3 memory access unit
package lc3_mem_pkg;

    localparam int ADDR_W_DFLT  = 16;
    localparam int DATA_W_DFLT  = 16;
    localparam int TIMEOUT_DFLT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_e;

endpackage

// File: rtl/lc3_mau_wait_cnt.sv
// rtl/lc3_mau_wait_cnt.sv - WAIT-cycle counter that flags the last permitted wait cycle
module lc3_mau_wait_cnt #(
    parameter int TIMEOUT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear while the command is being issued so WAIT always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle whose count is TIMEOUT-1 is the TIMEOUT-th WAIT cycle.
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_access_unit.sv
// rtl/lc3_mem_access_unit.sv - LC-3 core-to-memory access FSM (optional wait timeout via LC3_MAU_TIMEOUT_EN)
module lc3_mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_complete
);

    mau_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              we_q, we_d;

`ifdef LC3_MAU_TIMEOUT_EN
    logic err_q, err_d;
    logic expired;

    lc3_mau_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Next-state and datapath load decisions; mem_rd is 1 except for the cycle after a write accept.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        rd_d    = 1'b1;
`ifdef LC3_MAU_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                    we_d    = req_we;
                    rd_d    = ~req_we;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_complete) begin
                    if (!we_q) begin
                        rdata_d = mem_dout;
                    end
`ifdef LC3_MAU_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_DONE;
                end
`ifdef LC3_MAU_TIMEOUT_EN
                else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b1;
            we_q    <= 1'b0;
`ifdef LC3_MAU_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
`ifdef LC3_MAU_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign ack      = (state_q == ST_DONE);
    assign rdata    = rdata_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_rd   = rd_q;
`ifdef LC3_MAU_TIMEOUT_EN
    assign err      = ack & err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_access_unit.sv
// tb/tb_lc3_mem_access_unit.sv - directed self-checking bench for lc3_mem_access_unit
module tb_lc3_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        ready;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_rd;
    logic [15:0] mem_dout;
    logic        mem_complete;

    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic [15:0] mem [0:65535];

    int checks;
    int failures;

    lc3_mem_access_unit #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ready        (ready),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_rd       (mem_rd),
        .mem_dout     (mem_dout),
        .mem_complete (mem_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory: write on mem_rd=0, read data registered one edge after the address.
    always @(posedge clock) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (!mem_rd) begin
            mem[mem_addr] <= mem_din;
        end
        mem_dout <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clock);
        #1;
        ld_en   = 1'b0;
    endtask

    // Entered and left at #1 after a rising edge; cycle 0 is the request cycle.
    task automatic access(input string tag, input logic we, input logic [15:0] a,
                          input logic [15:0] wd, input int stall, input int exp_ack,
                          input logic [15:0] exp_rdata, input logic exp_err, input int exp_wr);
        int          ack_cyc;
        int          wr_cnt;
        int          rdy_cnt;
        logic [15:0] got_rdata;
        logic        got_err;
        logic [15:0] got_addr;
        ack_cyc   = -1;
        wr_cnt    = 0;
        rdy_cnt   = 0;
        got_rdata = '0;
        got_err   = 1'b0;
        got_addr  = '0;
        req       = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
            mem_complete = !(c >= 2 && c < 2 + stall);
            @(negedge clock);
            if (ready) rdy_cnt++;
            if (!mem_rd) wr_cnt++;
            if (ack) begin
                ack_cyc   = c;
                got_rdata = rdata;
                got_err   = err;
                got_addr  = mem_addr;
            end
            @(posedge clock);
            #1;
            req = 1'b0;
        end
        mem_complete = 1'b1;
        check($sformatf("%s_ack_cycle", tag), 32'(ack_cyc), 32'(exp_ack));
        check($sformatf("%s_rdata", tag), 32'(got_rdata), 32'(exp_rdata));
        check($sformatf("%s_err", tag), 32'(got_err), 32'(exp_err));
        check($sformatf("%s_write_cycles", tag), 32'(wr_cnt), 32'(exp_wr));
        check($sformatf("%s_ready_cycles", tag), 32'(rdy_cnt), 32'd1);
        check($sformatf("%s_mem_addr", tag), 32'(got_addr), 32'(a));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        req          = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_complete = 1'b1;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        preload(16'h3009, 16'h0023);
        preload(16'hFFFF, 16'hBEEF);

        access("rd3009", 1'b0, 16'h3009, 16'h0000, 0, 3, 16'h0023, 1'b0, 0);
        access("wr300C", 1'b1, 16'h300C, 16'h0024, 0, 3, 16'h0023, 1'b0, 1);
        check("mem300C", 32'(mem[16'h300C]), 32'h0024);

        access("b2b_wr300B", 1'b1, 16'h300B, 16'h300C, 0, 3, 16'h0023, 1'b0, 1);
        access("b2b_rd300B", 1'b0, 16'h300B, 16'h0000, 0, 3, 16'h300C, 1'b0, 0);

        access("stall5", 1'b0, 16'h300C, 16'h0000, 5, 8, 16'h0024, 1'b0, 0);

        access("rdFFFF", 1'b0, 16'hFFFF, 16'h0000, 0, 3, 16'hBEEF, 1'b0, 0);
        @(negedge clock);
        check("addr_hold", 32'(mem_addr), 32'hFFFF);
        check("idle_mem_rd", 32'(mem_rd), 32'd1);
        @(posedge clock);
        #1;

`ifdef LC3_MAU_TIMEOUT_EN
        access("timeout", 1'b0, 16'h3009, 16'h0000, 100, 10, 16'h0000, 1'b1, 0);
        access("after_to", 1'b0, 16'h3009, 16'h0000, 0, 3, 16'h0023, 1'b0, 0);
`endif

        req          = 1'b1;
        req_we       = 1'b0;
        req_addr     = 16'h3009;
        mem_complete = 1'b0;
        @(posedge clock);
        #1;
        req = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_mem_rd", 32'(mem_rd), 32'd1);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        mem_complete = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("postrst_no_ack%0d", i), 32'(ack), 32'd0);
            @(posedge clock);
            #1;
        end
        access("postrst_rd", 1'b0, 16'h300B, 16'h0000, 0, 3, 16'h300C, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
